// File: rtl/keypad_matrix_emulator.sv
// Keypad side of a 4x4 column-scan matrix: pulls the commanded key's row low while the key is held.
// Optional contact chatter on press and release is built when KEYPAD_BOUNCE_EN is defined.
module keypad_matrix_emulator #(
  parameter int HOLD_W        = 8,
  parameter int GAP_SIGHTS    = 2
`ifdef KEYPAD_BOUNCE_EN
  ,
  parameter int BOUNCE_SIGHTS = 3
`endif
) (
  input  logic              scan_clk,
  input  logic              rst_n_,
  input  logic [3:0]        keyboard_col,
  output logic [3:0]        keyboard_row,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_index,
  input  logic [HOLD_W-1:0] cmd_hold,
  output logic              busy,
  output logic              done,
  output logic [1:0]        dbg_state
);

  // Command handshake: a command transfers on a scan_clk rising edge where cmd_valid and
  // cmd_ready are both high; cmd_valid may drop before that without effect, and cmd_index /
  // cmd_hold are only looked at on the transferring edge.

  localparam int GAP_W = $clog2(GAP_SIGHTS + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRESS = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t              r_state;
  logic [1:0]          r_key_col;
  logic [1:0]          r_key_row;
  logic [HOLD_W-1:0]   r_hold;
  logic [HOLD_W-1:0]   r_press_cnt;
  logic [GAP_W-1:0]    r_gap_cnt;
  logic                r_done;

  state_t              w_state_nxt;
  logic [HOLD_W-1:0]   w_press_cnt_nxt;
  logic [GAP_W-1:0]    w_gap_cnt_nxt;
  logic                w_done_nxt;
  logic                w_accept;
  logic                w_cmd_ready;
  logic                w_busy;
  logic                w_col_ok;
  logic [1:0]          w_col_idx;
  logic                w_sight;
  logic                w_press_on;
  logic                w_gap_on;
  logic                w_drive;
  logic [HOLD_W-1:0]   w_hold_eff;

  // Exactly one low line selects a column; anything else means no column is being scanned.
  always_comb begin
    w_col_ok  = 1'b1;
    w_col_idx = 2'd0;
    case (keyboard_col)
      4'b0111: w_col_idx = 2'd0;
      4'b1011: w_col_idx = 2'd1;
      4'b1101: w_col_idx = 2'd2;
      4'b1110: w_col_idx = 2'd3;
      default: w_col_ok  = 1'b0;
    endcase
  end

  assign w_sight    = w_col_ok && (w_col_idx == r_key_col);
  assign w_hold_eff = (cmd_hold == '0) ? HOLD_W'(1) : cmd_hold;

  always_comb begin
    w_state_nxt     = r_state;
    w_press_cnt_nxt = r_press_cnt;
    w_gap_cnt_nxt   = r_gap_cnt;
    w_done_nxt      = 1'b0;
    w_accept        = 1'b0;
    w_cmd_ready     = 1'b0;
    w_busy          = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cmd_ready = 1'b1;
        if (cmd_valid) begin
          w_accept        = 1'b1;
          w_press_cnt_nxt = '0;
          w_state_nxt     = S_PRESS;
        end
      end
      S_PRESS: begin
        w_busy = 1'b1;
        if (w_sight) begin
          if (r_press_cnt == r_hold - HOLD_W'(1)) begin
            w_press_cnt_nxt = '0;
            w_gap_cnt_nxt   = '0;
            w_state_nxt     = S_GAP;
          end else begin
            w_press_cnt_nxt = r_press_cnt + HOLD_W'(1);
          end
        end
      end
      S_GAP: begin
        w_busy = 1'b1;
        if (w_sight) begin
          if (r_gap_cnt == GAP_W'(GAP_SIGHTS - 1)) begin
            w_gap_cnt_nxt = '0;
            w_done_nxt    = 1'b1;
            w_state_nxt   = S_IDLE;
          end else begin
            w_gap_cnt_nxt = r_gap_cnt + GAP_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge scan_clk or negedge rst_n_) begin
    if (!rst_n_) begin
      r_state     <= S_IDLE;
      r_key_col   <= 2'd0;
      r_key_row   <= 2'd0;
      r_hold      <= '0;
      r_press_cnt <= '0;
      r_gap_cnt   <= '0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_press_cnt <= w_press_cnt_nxt;
      r_gap_cnt   <= w_gap_cnt_nxt;
      r_done      <= w_done_nxt;
      if (w_accept) begin
        r_key_col <= cmd_index[3:2];
        r_key_row <= cmd_index[1:0];
        r_hold    <= w_hold_eff;
      end
    end
  end

`ifdef KEYPAD_BOUNCE_EN
  // Early press sightings contact only on odd counts, early release sightings only on even counts.
  assign w_press_on = (32'(r_press_cnt) >= BOUNCE_SIGHTS) || r_press_cnt[0];
  assign w_gap_on   = (32'(r_gap_cnt) < BOUNCE_SIGHTS) && !r_gap_cnt[0];
`else
  assign w_press_on = 1'b1;
  assign w_gap_on   = 1'b0;
`endif

  // Row drive is combinational so it settles before the scanner samples on the opposite edge.
  assign w_drive = w_sight && (((r_state == S_PRESS) && w_press_on) ||
                               ((r_state == S_GAP)   && w_gap_on));

  assign keyboard_row = w_drive ? ~(4'b1000 >> r_key_row) : 4'b1111;
  assign cmd_ready    = w_cmd_ready;
  assign busy         = w_busy;
  assign done         = r_done;
  assign dbg_state    = r_state;

endmodule
